alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor of the team's 4-op ALU. It adds valid/ready flow control on both sides, a registered result with back-pressure, logical right shift, and iterative multi-cycle shifting of one bit per clock. It sits between an operand-issuing controller and a result consumer, and keeps the established 4-bit status word layout.

## Interface
Parameters:
- BITS, 8, operand/result width; must be ≥ 2.
- SHW, $clog2(BITS)+1, width of the shift down-counter.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  operand/op offered.
- o_ready  out  1  block can accept; high only in IDLE.
- i_a  in  BITS  operand A.
- i_b  in  BITS  operand B; shift amount or bit index for shift/CHG.
- i_op  in  3  operation code.
- o_valid  out  1  result held in o_out/o_status.
- i_ready  in  1  consumer takes result.
- o_out  out  BITS  registered result.
- o_status  out  4  registered flags: [0] ERROR, [1] EVEN, [2] OVF, [3] SINGLE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Acceptance occurs on a cycle with i_valid && o_ready. A, B and op are captured, and the transfer happens in that same cycle.
- Op codes (all unsigned):
  - 000 SUB: out = (A−B) mod 2^BITS; OVF = (A<B).
  - 001 CMP: out[0] = A>B, out[1] = A==B, out[2] = A<B, other bits 0; OVF = 0.
  - 010 SHL and 011 SHR: logical shift of A by B.
    - OVF = 1 if any 1 is shifted out.
    - If B ≥ BITS: ERROR = 1, out = 0, OVF = 0, no iteration.
  - 100 CHG: out = A with bit B inverted.
    - If B ≥ BITS: ERROR = 1, out = A.
  - 101–111: reserved; ERROR = 1, out = 0.
- ERROR = 0 unless stated above.
- Transitions:
  - IDLE → BUSY on acceptance of SHL/SHR with 0 < B < BITS; counter = B, working reg = A.
  - IDLE → DONE on acceptance of any other op, including shift by 0 (out = A, OVF = 0).
  - BUSY: each cycle, shift working reg one bit, OR the shifted-out bit into OVF, decrement counter. At counter == 1 the final shift is done; move to DONE.
  - DONE → IDLE when i_ready.
- EVEN and SINGLE are derived from final out on entry to DONE:
  - Z = number of zero bits in out.
  - EVEN = (Z mod 2 == 0), including Z = 0.
  - SINGLE = (Z == 1).
  - Otherwise both are 0.
- o_out/o_status hold their value from DONE until the next entry to DONE; they are not cleared on handoff.
- i_valid in BUSY/DONE is ignored; no queueing.

## Timing
- Reset (asynchronous, immediate): state = IDLE, o_valid = 0, o_out = 0, o_status = 0, counter = 0. o_ready = 1 while in IDLE, including during reset.
- Latency from acceptance cycle T to first o_valid cycle:
  - Non-iterative ops: T+1.
  - Shift by n (0<n<BITS): T+1+n.
- Throughput: at most one op per 2 cycles. o_ready is 0 through BUSY and DONE, and rises the cycle after the DONE handoff.
- o_valid = (state == DONE). While o_valid && !i_ready, o_out/o_status are stable for any number of cycles.
- Reset mid-BUSY or mid-DONE aborts the operation; no result is delivered.
- o_ready and o_valid are purely state-decoded, with no combinational path from i_valid/i_ready.

## Structure
- Package alu_seq_pkg holds:
  - op_t enum (OP_SUB, OP_CMP, OP_SHL, OP_SHR, OP_CHG).
  - state_t enum (IDLE, BUSY, DONE).
  - Status bit index constants ERROR_BIT=0, EVEN_BIT=1, OVF_BIT=2, SINGLE_BIT=3.
- Sub-module alu_flags (#BITS): combinational zero count of a BITS vector → EVEN and SINGLE. Instantiated once on the next-result value so the flags register together with out.
- Datapath and FSM stay in alu_seq; no other sub-modules.

## Test plan
All scenarios use BITS = 8.
- SUB A=8'h05, B=8'h07, accept at T → o_valid at T+1, o_out=8'hFE, o_status=4'b1100.
- SHL A=8'h81, B=3 → o_valid exactly at T+4, o_out=8'h08, o_status=4'b0100; o_ready=0 from T+1 until handoff.
- CHG A=8'h00, B=9 → T+1: o_out=8'h00, o_status=4'b0011. Reserved op 3'b111 → o_out=8'h00, o_status=4'b0011.
- CMP A=B=8'h03 with i_ready held 0 for 3 cycles; i_valid with new operands pulsed during hold:
  - o_out=8'h02 and o_status=4'b0000 stable throughout.
  - New request ignored; accepted only after handoff + 1 cycle.
- SHR A=8'hFF, B=6; assert i_rst asynchronously during 3rd BUSY cycle:
  - o_valid=0, o_out=0, o_status=0 immediately.
  - After release, o_ready=1 and a fresh SUB completes correctly.
- Shift by 0 (SHL A=8'hA5, B=0) → T+1, o_out=8'hA5, OVF=0, EVEN=1 (Z=4), o_status=4'b0010.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the bit positions inside the 4-bit status word.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_SUB = 3'b000,
    OP_CMP = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_CHG = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ERROR_BIT  = 0;
  localparam int EVEN_BIT   = 1;
  localparam int OVF_BIT    = 2;
  localparam int SINGLE_BIT = 3;

endpackage

// File: rtl/alu_flags.sv
// alu_flags
// Counts the zero bits of a result word and derives the parity-style flags.
// Ports:
//   i_vec     in  BITS  candidate result
//   o_even    out 1     zero count is even (zero zeros counts as even)
//   o_single  out 1     exactly one zero bit
module alu_flags #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] i_vec,
  output logic            o_even,
  output logic            o_single
);

  localparam int ZW = $clog2(BITS + 1);

  logic [ZW-1:0] zcnt;

  always_comb begin
    zcnt = '0;
    for (int i = 0; i < BITS; i++) begin
      zcnt = zcnt + ZW'(!i_vec[i]);
    end
  end

  assign o_even   = ~zcnt[0];
  assign o_single = (zcnt == ZW'(1));

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Handshaked ALU with a registered result. Shifts by 0 < B < BITS iterate
// one bit per clock; every other operation completes in one cycle.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid / o_ready   operand handshake (o_ready high only in IDLE)
//   i_a, i_b, i_op      operands and operation code
//   o_valid / i_ready   result handshake (o_valid high only in DONE)
//   o_out, o_status     registered result and {SINGLE, OVF, EVEN, ERROR}
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int BITS = 8,
  parameter int SHW  = $clog2(BITS) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic [2:0]      i_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_out,
  output logic [3:0]      o_status
);

  // One extra bit so BITS itself is representable for the range check.
  localparam logic [BITS:0] LIM = (BITS + 1)'(BITS);

  state_t          state_q, state_d;
  logic [BITS-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            shl_q, shl_d;
  logic [BITS-1:0] out_q, out_d;
  logic [3:0]      status_q, status_d;

  logic            b_ok;
  logic            load;
  logic [BITS-1:0] res_val;
  logic            res_err;
  logic            res_ovf;
  logic            step_bit;
  logic [BITS-1:0] work_step;
  logic [2:0]      cmp_vec;
  logic            flag_even;
  logic            flag_single;

  assign b_ok    = ({1'b0, i_b} < LIM);
  assign cmp_vec = {i_a < i_b, i_a == i_b, i_a > i_b};

  // One-bit step of the iterative shifter and the bit it pushes out.
  assign step_bit  = shl_q ? work_q[BITS-1] : work_q[0];
  assign work_step = shl_q ? {work_q[BITS-2:0], 1'b0} : {1'b0, work_q[BITS-1:1]};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    shl_d   = shl_q;
    load    = 1'b0;
    res_val = out_q;
    res_err = 1'b0;
    res_ovf = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          load    = 1'b1;
          state_d = DONE;
          case (i_op)
            OP_SUB: begin
              res_val = i_a - i_b;
              res_ovf = (i_a < i_b);
            end
            OP_CMP: begin
              res_val = BITS'(cmp_vec);
            end
            OP_SHL, OP_SHR: begin
              if (!b_ok) begin
                res_err = 1'b1;
                res_val = '0;
              end else if (i_b == '0) begin
                res_val = i_a;
              end else begin
                // Real shift: defer the result until the last BUSY step.
                load    = 1'b0;
                state_d = BUSY;
                cnt_d   = SHW'(i_b);
                work_d  = i_a;
                ovf_d   = 1'b0;
                shl_d   = (i_op == OP_SHL);
              end
            end
            OP_CHG: begin
              if (b_ok) begin
                res_val = i_a ^ (BITS'(1) << i_b);
              end else begin
                res_err = 1'b1;
                res_val = i_a;
              end
            end
            default: begin
              res_err = 1'b1;
              res_val = '0;
            end
          endcase
        end
      end
      BUSY: begin
        work_d = work_step;
        ovf_d  = ovf_q | step_bit;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
          load    = 1'b1;
          res_val = work_step;
          res_ovf = ovf_q | step_bit;
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flags are computed on the value about to be registered so that o_out
  // and o_status always change together.
  alu_flags #(.BITS(BITS)) u_flags (
    .i_vec   (res_val),
    .o_even  (flag_even),
    .o_single(flag_single)
  );

  always_comb begin
    out_d    = out_q;
    status_d = status_q;
    if (load) begin
      out_d                = res_val;
      status_d[ERROR_BIT]  = res_err;
      status_d[EVEN_BIT]   = flag_even;
      status_d[OVF_BIT]    = res_ovf;
      status_d[SINGLE_BIT] = flag_single;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      shl_q    <= 1'b0;
      out_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      shl_q    <= shl_d;
      out_q    <= out_d;
      status_q <= status_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_out    = out_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_out;
  logic [3:0] o_status;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.BITS(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (a),
    .i_b     (b),
    .i_op    (op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_out   (o_out),
    .o_status(o_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eo;
    logic [3:0] es;
    int         el;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the operation rules, using plain
  // arithmetic on wide integers.
  function automatic void model(input logic [2:0] op_v, input logic [7:0] a_v,
                                input logic [7:0] b_v, output logic [7:0] o,
                                output logic [3:0] st, output int lat);
    logic err, ovf;
    int   z;
    int   wide;
    err = 1'b0; ovf = 1'b0; o = '0; lat = 1;
    case (op_v)
      3'd0: begin o = a_v - b_v; ovf = (a_v < b_v); end
      3'd1: o = {5'b0, a_v < b_v, a_v == b_v, a_v > b_v};
      3'd2, 3'd3: begin
        if (b_v >= 8) err = 1'b1;
        else begin
          if (op_v == 3'd2) begin
            wide = int'(a_v) * (1 << b_v);
            o    = wide[7:0];
            ovf  = (wide >= 256);
          end else begin
            o   = 8'(int'(a_v) / (1 << b_v));
            ovf = (int'(a_v) % (1 << b_v)) != 0;
          end
          lat = 1 + int'(b_v);
        end
      end
      3'd4: begin
        if (b_v >= 8) begin err = 1'b1; o = a_v; end
        else o = a_v ^ 8'(1 << b_v);
      end
      default: err = 1'b1;
    endcase
    z  = 8 - $countones(o);
    st = {z == 1, ovf, (z % 2) == 0, err};
  endfunction

  task automatic run_op(input logic [2:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                        output logic [7:0] out_v, output logic [3:0] st_v,
                        output int lat, output bit ready_leak);
    int w;
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_wait: o_ready got 0 expected 1");
    end
    op = op_v; a = a_v; b = b_v; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    ready_leak = 1'b0;
    while (!o_valid && lat < 40) begin
      if (o_ready) ready_leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (o_ready) ready_leak = 1'b1;
    out_v = o_out;
    st_v  = o_status;
    $display("op=%0d a=%h b=%h out=%h status=%b latency=%0d", op_v, a_v, b_v, out_v, st_v, lat);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ro, eo;
    logic [3:0] rs, es;
    int         rl, el;
    bit         leak;

    tbl[0] = '{3'd0, 8'h05, 8'h07, 8'hFE, 4'b1100, 1};
    tbl[1] = '{3'd2, 8'h81, 8'h03, 8'h08, 4'b0100, 4};
    tbl[2] = '{3'd4, 8'h00, 8'h09, 8'h00, 4'b0011, 1};
    tbl[3] = '{3'd7, 8'h5A, 8'h01, 8'h00, 4'b0011, 1};
    tbl[4] = '{3'd2, 8'hA5, 8'h00, 8'hA5, 4'b0010, 1};
    tbl[5] = '{3'd3, 8'h0F, 8'h02, 8'h03, 4'b0110, 3};
    tbl[6] = '{3'd1, 8'h05, 8'h03, 8'h01, 4'b0000, 1};

    // Reset state
    #3 rst = 1'b1;
    #4;
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_out", o_out, 0);
    chk("rst_status", o_status, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, ro, rs, rl, leak);
      chk($sformatf("tbl%0d_out", i), ro, tbl[i].eo);
      chk($sformatf("tbl%0d_status", i), rs, tbl[i].es);
      chk($sformatf("tbl%0d_latency", i), rl, tbl[i].el);
      chk($sformatf("tbl%0d_ready_low", i), leak, 0);
      chk($sformatf("tbl%0d_valid_drop", i), o_valid, 0);
    end

    // CMP with result held under back-pressure while a new request is offered
    @(negedge clk);
    chk("hold_ready", o_ready, 1);
    op = 3'd1; a = 8'h03; b = 8'h03; i_valid = 1'b1;
    @(negedge clk);
    op = 3'd0; a = 8'h09; b = 8'h04;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_valid", k), o_valid, 1);
      chk($sformatf("hold%0d_out", k), o_out, 8'h02);
      chk($sformatf("hold%0d_status", k), o_status, 4'b0000);
      chk($sformatf("hold%0d_ready", k), o_ready, 0);
      @(negedge clk);
    end
    chk("hold_out_final", o_out, 8'h02);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("handoff_valid", o_valid, 0);
    chk("handoff_ready", o_ready, 1);
    $display("op=1 a=03 b=03 held 3 cycles, out=02 status=0000");
    @(negedge clk);
    i_valid = 1'b0;
    chk("queued_valid", o_valid, 1);
    chk("queued_out", o_out, 8'h05);
    chk("queued_status", o_status, 4'b0010);
    $display("op=0 a=09 b=04 out=%h status=%b", o_out, o_status);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;

    // Asynchronous reset during the third BUSY cycle of SHR by 6
    @(negedge clk);
    op = 3'd3; a = 8'hFF; b = 8'h06; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_ready", o_ready, 0);
    chk("busy_valid", o_valid, 0);
    rst = 1'b1;
    #1;
    chk("abort_valid", o_valid, 0);
    chk("abort_out", o_out, 0);
    chk("abort_status", o_status, 0);
    chk("abort_ready", o_ready, 1);
    $display("op=3 a=ff b=06 aborted by reset");
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 8'h10, 8'h01, ro, rs, rl, leak);
    chk("post_rst_out", ro, 8'h0F);
    chk("post_rst_status", rs, 4'b0010);
    chk("post_rst_latency", rl, 1);

    // Randomized operations against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [2:0] rop;
      logic [7:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      model(rop, ra, rb, eo, es, el);
      run_op(rop, ra, rb, ro, rs, rl, leak);
      chk($sformatf("rnd%0d_out", n), ro, eo);
      chk($sformatf("rnd%0d_status", n), rs, es);
      chk($sformatf("rnd%0d_latency", n), rl, el);
      chk($sformatf("rnd%0d_ready_low", n), leak, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
